// File: rtl/simon_sequence_engine.sv
// Simon game core: grows a random sequence, replays it with
// programmable timing and checks the player's entries step by step.
module simon_sequence_engine #(
  parameter int WIDTH          = 6,
  parameter int MAX_LEN        = 8,
  parameter int SHOW_CYCLES    = 5000000,
  parameter int GAP_CYCLES     = 1000000,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int LEN_W          = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] rand_in,
  input  logic [WIDTH-1:0] guess,
  input  logic             submit,
  output logic             show_valid,
  output logic [WIDTH-1:0] show_value,
  output logic [LEN_W-1:0] step_index,
  output logic [LEN_W-1:0] round_len,
  output logic [LEN_W-1:0] score,
  output logic [2:0]       phase,
  output logic             correct_pulse,
  output logic             wrong_pulse,
  output logic             win,
  output logic             lose
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPEND = 3'd1;
  localparam logic [2:0] S_SHOWON = 3'd2;
  localparam logic [2:0] S_SHOWOF = 3'd3;
  localparam logic [2:0] S_INPUT  = 3'd4;
  localparam logic [2:0] S_WIN    = 3'd5;
  localparam logic [2:0] S_LOSE   = 3'd6;

  localparam int  MAXC0 = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int  MAXC  = (MAXC0 > TIMEOUT_CYCLES) ? MAXC0 : TIMEOUT_CYCLES;
  localparam int  TW    = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int  AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int  TO_LD = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit  TO_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [TW-1:0]    T_SHOW  = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0]    T_GAP   = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0]    T_TO    = TW'(TO_LD);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [2:0]       phase_q, phase_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] score_q, score_d;
  logic [LEN_W-1:0] step_q, step_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             cp_q, cp_d;
  logic             wp_q, wp_d;
  logic             mem_we;
  logic [WIDTH-1:0] mem_q [MAX_LEN];
  logic [WIDTH-1:0] cur_val;
  logic             t_zero;
  logic             last;

  assign cur_val = mem_q[step_q[AW-1:0]];
  assign t_zero  = (timer_q == '0);
  assign last    = (step_q == len_q - 1'b1);

  always_comb begin
    phase_d = phase_q;
    len_d   = len_q;
    score_d = score_q;
    step_d  = step_q;
    timer_d = timer_q;
    cp_d    = 1'b0;
    wp_d    = 1'b0;
    mem_we  = 1'b0;
    if (start) begin
      phase_d = S_APPEND;
      len_d   = '0;
      score_d = '0;
      step_d  = '0;
    end else begin
      unique case (phase_q)
        S_APPEND: begin
          mem_we  = 1'b1;
          len_d   = len_q + 1'b1;
          step_d  = '0;
          timer_d = T_SHOW;
          phase_d = S_SHOWON;
        end
        S_SHOWON: begin
          if (t_zero) begin
            timer_d = T_GAP;
            phase_d = S_SHOWOF;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        S_SHOWOF: begin
          if (!t_zero) begin
            timer_d = timer_q - 1'b1;
          end else if (last) begin
            step_d  = '0;
            timer_d = T_TO;
            phase_d = S_INPUT;
          end else begin
            step_d  = step_q + 1'b1;
            timer_d = T_SHOW;
            phase_d = S_SHOWON;
          end
        end
        S_INPUT: begin
          if (submit) begin
            if (guess == cur_val) begin
              cp_d = 1'b1;
              if (last) begin
                score_d = score_q + 1'b1;
                phase_d = (len_q == LEN_MAX) ? S_WIN : S_APPEND;
              end else begin
                step_d  = step_q + 1'b1;
                timer_d = T_TO;
              end
            end else begin
              wp_d    = 1'b1;
              phase_d = S_LOSE;
            end
          end else if (TO_EN && t_zero) begin
            wp_d    = 1'b1;
            phase_d = S_LOSE;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= S_IDLE;
      len_q   <= '0;
      score_q <= '0;
      step_q  <= '0;
      timer_q <= '0;
      cp_q    <= 1'b0;
      wp_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      len_q   <= len_d;
      score_q <= score_d;
      step_q  <= step_d;
      timer_q <= timer_d;
      cp_q    <= cp_d;
      wp_q    <= wp_d;
    end
  end

  // Sequence storage is never cleared; only written entries are shown.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[len_q[AW-1:0]] <= rand_in;
    end
  end

  assign phase         = phase_q;
  assign show_valid    = (phase_q == S_SHOWON);
  assign show_value    = show_valid ? cur_val : '0;
  assign step_index    = step_q;
  assign round_len     = len_q;
  assign score         = score_q;
  assign correct_pulse = cp_q;
  assign wrong_pulse   = wp_q;
  assign win           = (phase_q == S_WIN);
  assign lose          = (phase_q == S_LOSE);

endmodule

// File: tb/tb_simon_sequence_engine.sv
// Directed bench for simon_sequence_engine: a cycle table for
// show/input/lose/start-priority plus full-game, timeout and reset runs.
module tb_simon_sequence_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       st_a = 0, sb_a = 0;
  logic [5:0] g_a = '0, r_a = '0;
  logic       sv_a, cp_a, wp_a, win_a, lose_a;
  logic [5:0] val_a;
  logic [1:0] stp_a, rl_a, sc_a;
  logic [2:0] ph_a;

  logic       st_b = 0, sb_b = 0;
  logic [5:0] g_b = '0, r_b = 6'd3;
  logic       sv_b, cp_b, wp_b, win_b, lose_b;
  logic [5:0] val_b;
  logic [2:0] stp_b, rl_b, sc_b;
  logic [2:0] ph_b;

  simon_sequence_engine #(
    .WIDTH(6), .MAX_LEN(3), .SHOW_CYCLES(3),
    .GAP_CYCLES(2), .TIMEOUT_CYCLES(0)
  ) dut_a (
    .clk(clk), .reset(rst_n), .start(st_a),
    .rand_in(r_a), .guess(g_a), .submit(sb_a),
    .show_valid(sv_a), .show_value(val_a),
    .step_index(stp_a), .round_len(rl_a),
    .score(sc_a), .phase(ph_a),
    .correct_pulse(cp_a), .wrong_pulse(wp_a),
    .win(win_a), .lose(lose_a)
  );

  simon_sequence_engine #(
    .WIDTH(6), .MAX_LEN(4), .SHOW_CYCLES(2),
    .GAP_CYCLES(1), .TIMEOUT_CYCLES(10)
  ) dut_b (
    .clk(clk), .reset(rst_n), .start(st_b),
    .rand_in(r_b), .guess(g_b), .submit(sb_b),
    .show_valid(sv_b), .show_value(val_b),
    .step_index(stp_b), .round_len(rl_b),
    .score(sc_b), .phase(ph_b),
    .correct_pulse(cp_b), .wrong_pulse(wp_b),
    .win(win_b), .lose(lose_b)
  );

  int checks = 0;
  int errors = 0;
  int ncp_a = 0;
  int nwp_a = 0;

  always @(negedge clk) begin
    if (cp_a) ncp_a++;
    if (wp_a) nwp_a++;
  end

  typedef struct {
    int st, sb, g, r;
    int ph, sv, val, stp, rl, sc, cp, wp;
  } vec_t;

  vec_t tbl[$];
  int   seq[3] = '{5, 17, 42};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ph_a(input int ph, input int lim);
    int n = 0;
    while (int'(ph_a) != ph && n < lim) begin
      step();
      n++;
    end
    chk("wait_phase_a", int'(ph_a), ph);
  endtask

  task automatic wait_ph_b(input int ph, input int lim);
    int n = 0;
    while (int'(ph_b) != ph && n < lim) begin
      step();
      n++;
    end
    chk("wait_phase_b", int'(ph_b), ph);
  endtask

  initial begin
    int c0, w0, n;
    string s;

    // st sb g r | ph sv val stp rl sc cp wp
    tbl.push_back(vec_t'{1,0,0,5,    1,0,0,0,0,0,0,0});
    repeat (3)
      tbl.push_back(vec_t'{0,0,0,5,  2,1,5,0,1,0,0,0});
    repeat (2)
      tbl.push_back(vec_t'{0,0,0,5,  3,0,0,0,1,0,0,0});
    tbl.push_back(vec_t'{0,0,0,5,    4,0,0,0,1,0,0,0});
    tbl.push_back(vec_t'{0,1,5,17,   1,0,0,0,1,1,1,0});
    tbl.push_back(vec_t'{0,0,0,17,   2,1,5,0,2,1,0,0});
    tbl.push_back(vec_t'{0,1,5,17,   2,1,5,0,2,1,0,0});
    tbl.push_back(vec_t'{0,0,0,17,   2,1,5,0,2,1,0,0});
    repeat (2)
      tbl.push_back(vec_t'{0,0,0,17, 3,0,0,0,2,1,0,0});
    repeat (3)
      tbl.push_back(vec_t'{0,0,0,17, 2,1,17,1,2,1,0,0});
    repeat (2)
      tbl.push_back(vec_t'{0,0,0,17, 3,0,0,1,2,1,0,0});
    tbl.push_back(vec_t'{0,0,0,17,   4,0,0,0,2,1,0,0});
    tbl.push_back(vec_t'{0,1,5,17,   4,0,0,1,2,1,1,0});
    tbl.push_back(vec_t'{0,1,40,17,  6,0,0,1,2,1,0,1});
    tbl.push_back(vec_t'{0,0,0,17,   6,0,0,1,2,1,0,0});
    tbl.push_back(vec_t'{0,1,17,17,  6,0,0,1,2,1,0,0});
    tbl.push_back(vec_t'{1,0,0,5,    1,0,0,0,0,0,0,0});
    repeat (3)
      tbl.push_back(vec_t'{0,0,0,5,  2,1,5,0,1,0,0,0});
    repeat (2)
      tbl.push_back(vec_t'{0,0,0,5,  3,0,0,0,1,0,0,0});
    tbl.push_back(vec_t'{0,0,0,5,    4,0,0,0,1,0,0,0});
    tbl.push_back(vec_t'{1,1,5,5,    1,0,0,0,0,0,0,0});
    tbl.push_back(vec_t'{0,0,0,5,    2,1,5,0,1,0,0,0});

    repeat (3) step();
    chk("rst_phase_a", int'(ph_a), 0);
    chk("rst_len_a", int'(rl_a), 0);
    chk("rst_score_a", int'(sc_a), 0);
    chk("rst_step_a", int'(stp_a), 0);
    chk("rst_show_a", int'(sv_a), 0);
    chk("rst_phase_b", int'(ph_b), 0);
    rst_n = 1'b1;
    repeat (2) step();
    chk("idle_after_rst", int'(ph_a), 0);

    foreach (tbl[i]) begin
      st_a = 1'(tbl[i].st);
      sb_a = 1'(tbl[i].sb);
      g_a  = 6'(tbl[i].g);
      r_a  = 6'(tbl[i].r);
      step();
      s = $sformatf("row%0d", i);
      chk({s, ".phase"}, int'(ph_a), tbl[i].ph);
      chk({s, ".show_valid"}, int'(sv_a), tbl[i].sv);
      chk({s, ".show_value"}, int'(val_a), tbl[i].val);
      chk({s, ".step"}, int'(stp_a), tbl[i].stp);
      chk({s, ".round_len"}, int'(rl_a), tbl[i].rl);
      chk({s, ".score"}, int'(sc_a), tbl[i].sc);
      chk({s, ".correct"}, int'(cp_a), tbl[i].cp);
      chk({s, ".wrong"}, int'(wp_a), tbl[i].wp);
      chk({s, ".win"}, int'(win_a), int'(tbl[i].ph == 5));
      chk({s, ".lose"}, int'(lose_a), int'(tbl[i].ph == 6));
    end
    st_a = 0;
    sb_a = 0;

    // Full game with all-correct entries
    c0 = ncp_a;
    w0 = nwp_a;
    r_a = 6'(seq[0]);
    st_a = 1;
    step();
    st_a = 0;
    for (int k = 0; k < 3; k++) begin
      wait_ph_a(4, 100);
      if (k == 0) begin
        repeat (1000) step();
        chk("no_timeout_phase", int'(ph_a), 4);
        chk("no_timeout_wrong", nwp_a - w0, 0);
      end
      for (int i = 0; i <= k; i++) begin
        g_a = 6'(seq[i]);
        if (i == k && k < 2) r_a = 6'(seq[k + 1]);
        sb_a = 1;
        step();
        sb_a = 0;
      end
    end
    step();
    chk("game_correct_cnt", ncp_a - c0, 6);
    chk("game_wrong_cnt", nwp_a - w0, 0);
    chk("game_score", int'(sc_a), 3);
    chk("game_len", int'(rl_a), 3);
    chk("game_win", int'(win_a), 1);
    chk("game_lose", int'(lose_a), 0);
    chk("game_phase", int'(ph_a), 5);
    for (int i = 0; i < 3; i++) begin
      g_a = 6'(seq[i]);
      sb_a = 1;
      step();
      sb_a = 0;
      step();
    end
    chk("win_submit_correct", ncp_a - c0, 6);
    chk("win_submit_wrong", nwp_a - w0, 0);
    chk("win_hold_score", int'(sc_a), 3);
    chk("win_hold_phase", int'(ph_a), 5);

    // Timeout in INPUT
    st_b = 1;
    step();
    st_b = 0;
    wait_ph_b(4, 100);
    n = 0;
    while (!wp_b && n < 50) begin
      step();
      n++;
    end
    chk("timeout_cycles", n, 10);
    chk("timeout_phase", int'(ph_b), 6);
    chk("timeout_lose", int'(lose_b), 1);
    chk("timeout_len", int'(rl_b), 1);
    step();
    chk("timeout_pulse_width", int'(wp_b), 0);

    // Asynchronous reset during SHOW_ON
    st_b = 1;
    step();
    st_b = 0;
    wait_ph_b(2, 20);
    chk("pre_reset_show", int'(sv_b), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_phase", int'(ph_b), 0);
    chk("async_rst_show_valid", int'(sv_b), 0);
    chk("async_rst_show_value", int'(val_b), 0);
    chk("async_rst_len", int'(rl_b), 0);
    chk("async_rst_score", int'(sc_b), 0);
    chk("async_rst_step", int'(stp_b), 0);
    chk("async_rst_pulses", int'({cp_b, wp_b, win_b, lose_b}), 0);
    #2;
    rst_n = 1'b1;
    repeat (5) step();
    chk("post_rst_idle", int'(ph_b), 0);
    chk("post_rst_len", int'(rl_b), 0);
    chk("post_rst_show", int'(sv_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
